pipe_skid_reg: RTL

//  Parametrised pipeline stage register for inter-stage boundaries (IF/ID .. MEM/WR).

---
 rtl/pipe_skid_reg.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, flush and one-entry skid.
// State advances on the falling edge of Clk; Rst is asynchronous, active-high.
//
// Ports:
//   Clk, Rst             clock (negedge active) and async active-high reset
//   in_valid/in_ready    upstream handshake, in_data is the incoming payload
//   out_valid/out_ready  downstream handshake, out_data is the held payload
//   flush                kills every held entry at the next edge
//   cnt                  number of held entries (0..2)
module pipe_skid_reg #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FULL  = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire;
  logic              out_fire;

  // Handshake outputs decode state_q only, so in_ready
  // never sees out_ready combinationally. An illegal
  // encoding refuses input so nothing is silently lost
  // while it recovers to EMPTY.
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b0;
    cnt       = 2'd0;
    case (state_q)
      EMPTY: begin
        in_ready = 1'b1;
      end
      HALF: begin
        out_valid = 1'b1;
        in_ready  = 1'b1;
        cnt       = 2'd1;
      end
      FULL: begin
        out_valid = 1'b1;
        cnt       = 2'd2;
      end
      default: begin
        out_valid = 1'b0;
        in_ready  = 1'b0;
        cnt       = 2'd0;
      end
    endcase
  end

  assign out_data = main_q;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Payload registers are left stale on purpose.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = HALF;
          end
        end
        HALF: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = HALF;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(negedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
